xrad_mac_sequencer: RTL
=======================

XRAD_MAC_SEQUENCER -- requirements
Module: xrad_mac_sequencer

Interface
REQ-001 SHALL have ports: clk in 1 (sole clock); rst_n in 1 (async active-low reset).
REQ-002 SHALL have ports: start in 1 (job request); cfg_len in 8 (terms per job); busy out 1; done out 1 (one-cycle pulse).
REQ-003 SHALL have ports: s_valid in 1; s_ready out 1; s_a in 16; s_b in 16; s_w in 32 (operand stream: a = real sample, b = imag sample, w = {w_real, w_imag}).
REQ-004 SHALL have ports: mac_a out 16; mac_b out 16; mac_weight out 32; mac_clr_n out 1 (active-low accumulator clear); mac_result in 32 ({acc_real[31:16], acc_imag[31:16]}).
REQ-005 SHALL have ports: out_valid out 1; out_ready in 1; out_real out 16; out_imag out 16; err out 1 (sticky timeout flag).

Function
REQ-006 SHALL use FSM states IDLE, CLEAR, FEED, DRAIN, HOLD.
REQ-007 IDLE: start=1 SHALL latch cfg_len into len_q and go to CLEAR; start SHALL be ignored in every other state.
REQ-008 CLEAR: mac_clr_n SHALL be 0 for exactly one cycle, then 1 again. The next state SHALL be FEED, or DRAIN if len_q==0.
REQ-009 FEED: s_ready SHALL be 1 while term count < len_q. It SHALL be 0 in all other states and cycles.
REQ-010 On each s_valid&&s_ready beat, mac_a/mac_b/mac_weight SHALL register s_a/s_b/s_w and the count SHALL increment.
REQ-011 On non-beat cycles, mac_a/mac_b/mac_weight SHALL be driven to 0 so the accumulator holds its value.
REQ-012 When the count reaches len_q, the FSM SHALL go to DRAIN. The count SHALL be 8 bits. len=255 SHALL complete without wrap.
REQ-013 DRAIN SHALL last DRAIN_CYC=3 cycles with zero operands.
- These 3 cycles cover: operand register, multiply register, accumulate register.
REQ-014 On DRAIN exit, out_real SHALL capture mac_result[31:16] and out_imag SHALL capture mac_result[15:0]. out_valid SHALL then be set and the FSM SHALL go to HOLD.
REQ-015 HOLD: out_valid and out data SHALL stay stable until out_ready=1.
REQ-016 On the out_valid&&out_ready cycle, the FSM SHALL clear out_valid, pulse done, and return to IDLE.
REQ-017 A start asserted in the same cycle as the HOLD handshake SHALL be ignored. It is accepted only from IDLE on the following cycle.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 Latency SHALL be len_q + 5 cycles from start acceptance to out_valid, excluding stall cycles (cycles with s_valid=0 in FEED).

Reset
REQ-020 rst_n=0 SHALL asynchronously force the following to their reset values:
- state=IDLE, count=0;
- s_ready=0, busy=0, done=0, out_valid=0, err=0;
- out_real=0, out_imag=0;
- mac_a=0, mac_b=0, mac_weight=0;
- mac_clr_n=1.
REQ-021 Reset mid-job SHALL discard the job with no out_valid and no done. The next job SHALL begin with CLEAR as normal.

Configuration
REQ-022 With XRAD_MAC_SEQ_TIMEOUT_EN defined, FEED SHALL count consecutive cycles without a beat.
- On reaching TIMEOUT_CYC=256, the FSM SHALL set err=1 (sticky until reset) and go directly to DRAIN.
- The partial result SHALL be delivered normally.
REQ-023 Without XRAD_MAC_SEQ_TIMEOUT_EN, err SHALL be tied 0 and FEED SHALL wait for beats indefinitely.

Structure
REQ-024 The state enum, DRAIN_CYC and TIMEOUT_CYC SHALL live in the shared package xrad_pkg.
REQ-025 The module SHALL be a single flat module with no sub-modules. It SHALL not instantiate the MAC; it connects to it at the parent level.

Verification
REQ-026 Bench SHALL wire the sequencer to the real MAC unit and cover:
- len=4, each beat s_a=16'h0100, s_b=0, s_w={16'h0100,16'h0000}, no stalls -> out_valid at cycle 9 after start, out_real=16'h0004, out_imag=16'h0000, done pulse after out_ready.
- len=0 -> one clear pulse, no s_ready, out_valid after DRAIN, out_real=0, out_imag=0.
- len=3 with s_valid low for 5 cycles between beats 1 and 2 -> same result as an unstalled run; mac operands are 0 during the stall.
- out_ready held low 10 cycles in HOLD -> out data stable; start pulsed during HOLD is ignored; a second job runs only after a new start in IDLE.
- rst_n pulsed low during FEED at beat 2 of 6 -> all outputs at reset values immediately; a fresh len=2 job gives the correct result from a cleared accumulator.
- With XRAD_MAC_SEQ_TIMEOUT_EN, len=4 with only 1 beat then s_valid=0 -> after 256 idle cycles err=1, partial result delivered, err stays 1 across the next job.

Source files
------------

// File: rtl/xrad_pkg.sv
// Shared constants for the xrad MAC sequencer: state codes and pipeline/timeout lengths.
package xrad_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StClear = 3'd1;
  localparam state_t StFeed  = 3'd2;
  localparam state_t StDrain = 3'd3;
  localparam state_t StHold  = 3'd4;

  // Operand register + multiply register + accumulate register of the external MAC.
  localparam int unsigned DRAIN_CYC   = 3;
  localparam int unsigned TIMEOUT_CYC = 256;

endpackage

// File: rtl/xrad_mac_sequencer.sv
// Job sequencer for an external pipelined complex MAC: clear, stream len terms, drain, hand off.
// Define XRAD_MAC_SEQ_TIMEOUT_EN to abort a starved FEED into DRAIN and raise a sticky err.
module xrad_mac_sequencer
  import xrad_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  cfg_len,
  output logic        busy,
  output logic        done,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_a,
  input  logic [15:0] s_b,
  input  logic [31:0] s_w,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  output logic [31:0] mac_weight,
  output logic        mac_clr_n,
  input  logic [31:0] mac_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_real,
  output logic [15:0] out_imag,
  output logic        err
);

  state_t      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  count_q, count_d;
  logic [1:0]  drain_q, drain_d;
  logic [15:0] mac_a_q, mac_a_d;
  logic [15:0] mac_b_q, mac_b_d;
  logic [31:0] mac_w_q, mac_w_d;
  logic        clr_n_q, clr_n_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_real_q, out_real_d;
  logic [15:0] out_imag_q, out_imag_d;
  logic        done_q, done_d;
  logic        beat;
  logic        tmo;

  assign s_ready = (state_q == StFeed) && (count_q < len_q);
  assign beat    = s_valid && s_ready;
  assign busy    = (state_q != StIdle);

`ifdef XRAD_MAC_SEQ_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYC);

  logic [IdleW-1:0] idle_q;
  logic             err_q;

  // Fires on the TIMEOUT_CYC-th consecutive beat-less FEED cycle.
  assign tmo = (state_q == StFeed) && !beat && (idle_q == IdleW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q != StFeed || beat) begin
        idle_q <= '0;
      end else if (!tmo) begin
        idle_q <= idle_q + 1'b1;
      end
      if (tmo) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    drain_d     = drain_q;
    clr_n_d     = 1'b1;
    out_valid_d = out_valid_q;
    out_real_d  = out_real_q;
    out_imag_d  = out_imag_q;
    done_d      = 1'b0;
    // Zero operands on non-beat cycles keep the accumulator unchanged.
    mac_a_d     = beat ? s_a : 16'h0000;
    mac_b_d     = beat ? s_b : 16'h0000;
    mac_w_d     = beat ? s_w : 32'h0000_0000;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = cfg_len;
          clr_n_d = 1'b0;
          state_d = StClear;
        end
      end
      StClear: begin
        count_d = '0;
        drain_d = '0;
        state_d = (len_q == 8'd0) ? StDrain : StFeed;
      end
      StFeed: begin
        if (beat) begin
          count_d = count_q + 8'd1;
          if (count_q == len_q - 8'd1) begin
            state_d = StDrain;
          end
        end else if (tmo) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'(DRAIN_CYC - 1)) begin
          drain_d     = '0;
          out_valid_d = 1'b1;
          out_real_d  = mac_result[31:16];
          out_imag_d  = mac_result[15:0];
          state_d     = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      count_q     <= '0;
      drain_q     <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_w_q     <= '0;
      clr_n_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      drain_q     <= drain_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_w_q     <= mac_w_d;
      clr_n_q     <= clr_n_d;
      out_valid_q <= out_valid_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
      done_q      <= done_d;
    end
  end

  assign mac_a      = mac_a_q;
  assign mac_b      = mac_b_q;
  assign mac_weight = mac_w_q;
  assign mac_clr_n  = clr_n_q;
  assign out_valid  = out_valid_q;
  assign out_real   = out_real_q;
  assign out_imag   = out_imag_q;
  assign done       = done_q;

endmodule
